respawn_controller: RTL and testbench
=====================================

Name: respawn_controller

Overview:
- Per-player life-cycle sequencer sitting above the player movement block.
- Watches the player's position against blast zones, freezes and hides the player on a KO, and counts down a respawn delay in frames.
- Pulses the movement block's reset to put the player back at spawn, then runs a blinking invulnerability window.
- Tracks remaining stocks and declares game over; one instance per player, all driven by the shared frame_rate strobe.

Parameters:
STOCKS, 3, lives at match start (1..15)
RESPAWN_FRAMES, 60, frames hidden/frozen after a KO before respawn (0..255)
INVULN_FRAMES, 120, frames of invulnerability after respawn (1..255)
BLAST_Y, 470, y_pos >= this is a KO (bottom blast zone)
BLAST_X_MAX, 630, x_pos > this is a KO (covers right edge and 10-bit underflow wrap off the left edge)
BLINK_PERIOD, 8, frames per visible/hidden half-cycle while invulnerable (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  one clock; reset is asynchronous and active-low
frame_rate  in  1  one-clk strobe per video frame
start  in  1  one-clk pulse: begin match / rematch
x_pos  in  10  player x from movement block (unsigned)
y_pos  in  10  player y from movement block (unsigned)
move_reset  out  1  active-high reset to movement block
freeze  out  1  1 = movement buttons must be gated off
visible  out  1  1 = draw player sprite
invulnerable  out  1  1 = player ignores hits
stocks_left  out  4  remaining lives
game_over  out  1  1 = this player has no stocks left
state  out  3  current FSM state (for debug/HUD)

Behaviour:
- All outputs registered, Moore-style, decoded from state.
- reset low (async): state=WAIT_START, stocks_left=STOCKS, frame counter=0, blink phase=1.
  - Output values in WAIT_START: move_reset=1, freeze=1, visible=1, invulnerable=0, game_over=0.
- State encodings: WAIT_START=0, ALIVE=1, KO=2, RESPAWN=3, INVULN=4, GAME_OVER=5.
- WAIT_START: move_reset held 1. start -> ALIVE on next edge, and stocks_left reloads to STOCKS. frame_rate is ignored.
- ALIVE: move_reset=0, freeze=0, visible=1, invulnerable=0.
  - On a frame_rate cycle with blast (y_pos >= BLAST_Y or x_pos > BLAST_X_MAX):
    - stocks_left==1 -> GAME_OVER, stocks_left=0.
    - otherwise -> KO, stocks_left-1, counter=RESPAWN_FRAMES.
  - Blast is sampled only on frame_rate cycles.
- KO: freeze=1, visible=0, invulnerable=1.
  - On each frame_rate: counter==0 -> RESPAWN, else counter-1.
  - RESPAWN_FRAMES=0 therefore leaves KO on the first frame_rate.
- RESPAWN: lasts exactly one clk. move_reset=1, freeze=1, visible=0.
  - Next edge -> INVULN, counter=INVULN_FRAMES-1, blink phase=1.
- INVULN: move_reset=0, freeze=0, invulnerable=1, visible=blink phase.
  - Each frame_rate: blink phase toggles when (counter mod BLINK_PERIOD)==0.
  - counter==0 -> ALIVE, else counter-1.
  - Blast check is still active, with the same rules as ALIVE. Blast has priority over the counter expiring on the same frame.
- GAME_OVER: game_over=1, freeze=1, visible=0, invulnerable=1, move_reset=0, stocks_left=0.
  - start -> restock to STOCKS, go to RESPAWN. The player respawns with invulnerability.
- start is ignored in ALIVE, KO, RESPAWN and INVULN.
- Latency: blast detected on a frame_rate cycle -> freeze/visible change at the next clk edge. move_reset is high for exactly 1 clk per respawn.
- Counter is 8-bit and never wraps below 0; it is reloaded on every entry to KO or INVULN.
- reset asserted mid-operation (any state) returns to WAIT_START immediately. move_reset is asserted asynchronously with reset.
- Unused state encodings 6 and 7 -> WAIT_START on the next edge.

Test Plan:
1. Reset low then high, no start, 100 frames -> state=0, move_reset=1, freeze=1, stocks_left=3, game_over=0 throughout.
2. start; y_pos=480 on a frame_rate cycle -> next edge state=KO, stocks_left=2, visible=0, freeze=1. After 61 frame_rate strobes, move_reset high exactly 1 clk, then state=INVULN, freeze=0.
3. INVULN with BLINK_PERIOD=8 -> visible toggles every 8 frames, 120 frames total. On the 120th frame_rate, state=ALIVE, invulnerable=0, visible=1.
4. x_pos=1021 (left-edge underflow) in ALIVE -> KO. Repeat until stocks_left=1; the next blast -> GAME_OVER, stocks_left=0, game_over=1. start -> stocks_left=3, RESPAWN pulse, INVULN.
5. Blast on the same frame_rate as INVULN counter expiry -> KO taken, not ALIVE. start pulse during KO -> ignored.
6. Async reset pulse during KO mid-count (no clk edge) -> state=0, move_reset=1 immediately. After release, stocks_left=3.

Source files
------------

// File: rtl/respawn_controller.sv
// Per-player life-cycle sequencer: blast-zone KO detection, respawn delay,
// blinking invulnerability window and stock tracking, stepped by frame_rate.
module respawn_controller #(
  parameter int STOCKS         = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLAST_Y        = 470,
  parameter int BLAST_X_MAX    = 630,
  parameter int BLINK_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rate,
  input  logic       start,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic       move_reset,
  output logic       freeze,
  output logic       visible,
  output logic       invulnerable,
  output logic [3:0] stocks_left,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_START = 3'd0,
    ALIVE      = 3'd1,
    KO         = 3'd2,
    RESPAWN    = 3'd3,
    INVULN     = 3'd4,
    GAME_OVER  = 3'd5
  } state_e;

  localparam logic [3:0] STOCKS_L    = 4'(STOCKS);
  localparam logic [7:0] RESPAWN_CNT = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] INVULN_CNT  = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_MASK  = 8'(BLINK_PERIOD - 1);
  localparam logic [9:0] BLAST_Y_L   = 10'(BLAST_Y);
  localparam logic [9:0] BLAST_X_L   = 10'(BLAST_X_MAX);

  state_e     state_q, state_d;
  logic [3:0] stocks_q, stocks_d;
  logic [7:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;
  logic       move_reset_q, move_reset_d;
  logic       freeze_q, freeze_d;
  logic       visible_q, visible_d;
  logic       invuln_q, invuln_d;
  logic       game_over_q, game_over_d;

  logic       ko_hit_s;
  state_e     ko_state_s;
  logic [3:0] ko_stocks_s;

  // Blast detection and the shared KO outcome (last stock ends the match)
  always_comb begin
    ko_hit_s = frame_rate && ((y_pos >= BLAST_Y_L) || (x_pos > BLAST_X_L));
    if (stocks_q <= 4'd1) begin
      ko_state_s  = GAME_OVER;
      ko_stocks_s = 4'd0;
    end else begin
      ko_state_s  = KO;
      ko_stocks_s = stocks_q - 4'd1;
    end
  end

  // Next-state, stock, frame counter and blink phase logic
  always_comb begin
    state_d  = state_q;
    stocks_d = stocks_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    case (state_q)
      WAIT_START: begin
        if (start) begin
          state_d  = ALIVE;
          stocks_d = STOCKS_L;
        end else begin
          state_d = WAIT_START;
        end
      end
      ALIVE: begin
        if (ko_hit_s) begin
          state_d  = ko_state_s;
          stocks_d = ko_stocks_s;
          cnt_d    = RESPAWN_CNT;
        end else begin
          state_d = ALIVE;
        end
      end
      KO: begin
        if (frame_rate) begin
          if (cnt_q == 8'd0) begin
            state_d = RESPAWN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RESPAWN: begin
        state_d = INVULN;
        cnt_d   = INVULN_CNT;
        blink_d = 1'b1;
      end
      INVULN: begin
        // A blast outranks the window expiring on the same frame
        if (ko_hit_s) begin
          state_d  = ko_state_s;
          stocks_d = ko_stocks_s;
          cnt_d    = RESPAWN_CNT;
        end else if (frame_rate) begin
          if ((cnt_q & BLINK_MASK) == 8'd0) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end
          if (cnt_q == 8'd0) begin
            state_d = ALIVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_d  = RESPAWN;
          stocks_d = STOCKS_L;
        end else begin
          state_d = GAME_OVER;
        end
      end
      default: begin
        state_d  = WAIT_START;
        stocks_d = STOCKS_L;
        cnt_d    = 8'd0;
        blink_d  = 1'b1;
      end
    endcase
  end

  // Moore output decode from the next state so outputs land with the state
  always_comb begin
    move_reset_d = 1'b1;
    freeze_d     = 1'b1;
    visible_d    = 1'b1;
    invuln_d     = 1'b0;
    game_over_d  = 1'b0;
    case (state_d)
      WAIT_START: begin
        move_reset_d = 1'b1;
        freeze_d     = 1'b1;
        visible_d    = 1'b1;
      end
      ALIVE: begin
        move_reset_d = 1'b0;
        freeze_d     = 1'b0;
        visible_d    = 1'b1;
      end
      KO: begin
        move_reset_d = 1'b0;
        visible_d    = 1'b0;
        invuln_d     = 1'b1;
      end
      RESPAWN: begin
        visible_d = 1'b0;
        invuln_d  = 1'b1;
      end
      INVULN: begin
        move_reset_d = 1'b0;
        freeze_d     = 1'b0;
        visible_d    = blink_d;
        invuln_d     = 1'b1;
      end
      GAME_OVER: begin
        move_reset_d = 1'b0;
        visible_d    = 1'b0;
        invuln_d     = 1'b1;
        game_over_d  = 1'b1;
      end
      default: begin
        move_reset_d = 1'b1;
        freeze_d     = 1'b1;
        visible_d    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset forces move_reset high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_START;
      stocks_q     <= STOCKS_L;
      cnt_q        <= 8'd0;
      blink_q      <= 1'b1;
      move_reset_q <= 1'b1;
      freeze_q     <= 1'b1;
      visible_q    <= 1'b1;
      invuln_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stocks_q     <= stocks_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      move_reset_q <= move_reset_d;
      freeze_q     <= freeze_d;
      visible_q    <= visible_d;
      invuln_q     <= invuln_d;
      game_over_q  <= game_over_d;
    end
  end

  assign move_reset   = move_reset_q;
  assign freeze       = freeze_q;
  assign visible      = visible_q;
  assign invulnerable = invuln_q;
  assign stocks_left  = stocks_q;
  assign game_over    = game_over_q;
  assign state        = state_q;

endmodule

// File: tb/tb_respawn_controller.sv
// Scenario bench for respawn_controller: expected output snapshots are queued
// as stimulus is driven and compared once the DUT has clocked.
module tb_respawn_controller;

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_ALIVE = 3'd1;
  localparam logic [2:0] S_KO = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_INV = 3'd4;
  localparam logic [2:0] S_GO = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_rate = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x_pos = 10'd320;
  logic [9:0] y_pos = 10'd200;
  logic       move_reset, freeze, visible, invulnerable, game_over;
  logic [3:0] stocks_left;
  logic [2:0] state;

  logic [11:0] exp_q[$];
  logic [11:0] e, got;
  int checks = 0;
  int errors = 0;

  respawn_controller dut (
    .clk(clk), .reset(reset), .frame_rate(frame_rate), .start(start),
    .x_pos(x_pos), .y_pos(y_pos), .move_reset(move_reset), .freeze(freeze),
    .visible(visible), .invulnerable(invulnerable), .stocks_left(stocks_left),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  // Packing: {state, move_reset, freeze, visible, invulnerable, stocks, game_over}
  function automatic logic [11:0] exp_out(input logic [2:0] st, input logic [3:0] stk,
                                          input logic blink);
    case (st)
      S_WAIT:  return {st, 1'b1, 1'b1, 1'b1, 1'b0, stk, 1'b0};
      S_ALIVE: return {st, 1'b0, 1'b0, 1'b1, 1'b0, stk, 1'b0};
      S_KO:    return {st, 1'b0, 1'b1, 1'b0, 1'b1, stk, 1'b0};
      S_RESP:  return {st, 1'b1, 1'b1, 1'b0, 1'b1, stk, 1'b0};
      S_INV:   return {st, 1'b0, 1'b0, blink, 1'b1, stk, 1'b0};
      S_GO:    return {st, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] observed();
    return {state, move_reset, freeze, visible, invulnerable, stocks_left, game_over};
  endfunction

  task automatic step(input logic fr, input logic st);
    frame_rate = fr;
    start = st;
    @(posedge clk);
    #1;
    frame_rate = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(exp_out(S_WAIT, 4'd3, 1'b1));
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_async got=%03h exp=%03h", got, e); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(exp_out(S_WAIT, 4'd3, 1'b1));
      step(1'b1, 1'b0);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) begin errors++; $display("FAIL wait_idle[%0d] got=%03h exp=%03h", i, got, e); end
    end
  endtask

  task automatic test_ko_respawn();
    exp_q.push_back(exp_out(S_ALIVE, 4'd3, 1'b1));
    step(1'b0, 1'b1);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL start_alive got=%03h exp=%03h", got, e); end
    y_pos = 10'd480;
    exp_q.push_back(exp_out(S_KO, 4'd2, 1'b0));
    step(1'b1, 1'b0);
    y_pos = 10'd200;
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL ko_entry got=%03h exp=%03h", got, e); end
    for (int i = 0; i < 60; i++) begin
      exp_q.push_back(exp_out(S_KO, 4'd2, 1'b0));
      step(1'b1, 1'b0);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) begin errors++; $display("FAIL ko_count[%0d] got=%03h exp=%03h", i, got, e); end
    end
    exp_q.push_back(exp_out(S_RESP, 4'd2, 1'b0));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL respawn_pulse got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_INV, 4'd2, 1'b1));
    step(1'b0, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL invuln_entry got=%03h exp=%03h", got, e); end
  endtask

  task automatic test_blink();
    for (int k = 1; k <= 120; k++) begin
      if (k < 120) exp_q.push_back(exp_out(S_INV, 4'd2, ((k / 8) % 2) == 0));
      else exp_q.push_back(exp_out(S_ALIVE, 4'd2, 1'b1));
      step(1'b1, 1'b0);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) begin errors++; $display("FAIL blink[%0d] got=%03h exp=%03h", k, got, e); end
    end
  endtask

  task automatic test_underflow_game_over();
    x_pos = 10'd630; y_pos = 10'd469;
    exp_q.push_back(exp_out(S_ALIVE, 4'd2, 1'b1));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL edge_no_blast got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_ALIVE, 4'd2, 1'b1));
    step(1'b0, 1'b1);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL start_ignored_alive got=%03h exp=%03h", got, e); end
    x_pos = 10'd1021; y_pos = 10'd200;
    exp_q.push_back(exp_out(S_KO, 4'd1, 1'b0));
    step(1'b1, 1'b0);
    x_pos = 10'd320;
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL underflow_ko got=%03h exp=%03h", got, e); end
    repeat (60) step(1'b1, 1'b0);
    exp_q.push_back(exp_out(S_RESP, 4'd1, 1'b0));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL respawn2 got=%03h exp=%03h", got, e); end
    step(1'b0, 1'b0);
    repeat (119) step(1'b1, 1'b0);
    exp_q.push_back(exp_out(S_ALIVE, 4'd1, 1'b1));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL alive_last_stock got=%03h exp=%03h", got, e); end
    x_pos = 10'd1021;
    exp_q.push_back(exp_out(S_GO, 4'd0, 1'b0));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL game_over got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_GO, 4'd0, 1'b0));
    step(1'b1, 1'b0);
    x_pos = 10'd320;
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL game_over_hold got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_RESP, 4'd3, 1'b0));
    step(1'b0, 1'b1);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL rematch_respawn got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_INV, 4'd3, 1'b1));
    step(1'b0, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL rematch_invuln got=%03h exp=%03h", got, e); end
  endtask

  task automatic test_blast_priority();
    repeat (119) step(1'b1, 1'b0);
    y_pos = 10'd470;
    exp_q.push_back(exp_out(S_KO, 4'd2, 1'b0));
    step(1'b1, 1'b0);
    y_pos = 10'd200;
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL blast_priority got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_KO, 4'd2, 1'b0));
    step(1'b0, 1'b1);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL start_ignored_ko got=%03h exp=%03h", got, e); end
  endtask

  task automatic test_async_reset();
    repeat (10) step(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(exp_out(S_WAIT, 4'd3, 1'b1));
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL async_reset_mid_ko got=%03h exp=%03h", got, e); end
    #1 reset = 1'b1;
    exp_q.push_back(exp_out(S_WAIT, 4'd3, 1'b1));
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL post_reset got=%03h exp=%03h", got, e); end
    exp_q.push_back(exp_out(S_ALIVE, 4'd3, 1'b1));
    step(1'b0, 1'b1);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) begin errors++; $display("FAIL post_reset_start got=%03h exp=%03h", got, e); end
  endtask

  initial begin
    test_reset();
    test_ko_respawn();
    test_blink();
    test_underflow_game_over();
    test_blast_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
